// File: rtl/bilinear_fetch_ctrl.sv
// Bilinear filter fetch sequencer: takes one sample request, reads the four
// neighbouring texels, pulses the filter enable and hands back the filtered colour.
module bilinear_fetch_ctrl #(
  parameter int UV_W   = 16,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [UV_W-1:0]   req_u,
  input  logic [UV_W-1:0]   req_v,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [3:0]        req_wlog2,
  input  logic [3:0]        req_hlog2,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rdata_valid,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       tex00,
  output logic [31:0]       tex10,
  output logic [31:0]       tex01,
  output logic [31:0]       tex11,
  output logic [7:0]        fracu,
  output logic [7:0]        fracv,
  output logic              bi_en,
  input  logic [31:0]       bi_color,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_color,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends combinationally on ready, and payload is stable while
  // valid is high and ready is low.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    FILTER = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        u_q, u_d;
  logic [7:0]        v_q, v_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        w_q, w_d;
  logic [3:0]        h_q, h_d;
  logic [2:0]        issued_q, issued_d;
  logic [2:0]        returned_q, returned_d;
  logic [31:0]       tex00_q, tex00_d;
  logic [31:0]       tex10_q, tex10_d;
  logic [31:0]       tex01_q, tex01_d;
  logic [31:0]       tex11_q, tex11_d;
  logic [7:0]        fracu_q, fracu_d;
  logic [7:0]        fracv_q, fracv_d;

  logic [7:0]        wmask, hmask;
  logic [7:0]        x0, x1, y0, y1, x_sel, y_sel;
  logic [15:0]       y_off, tex_off;
  logic [ADDR_W-1:0] addr;
  logic              mem_fire, ret_fire;
  logic [3:0]        w_clamp, h_clamp;

  assign w_clamp = (req_wlog2 > 4'd8) ? 4'd8 : req_wlog2;
  assign h_clamp = (req_hlog2 > 4'd8) ? 4'd8 : req_hlog2;

  // w_q/h_q never exceed 8, so shifting an all-ones byte right gives (1<<w)-1.
  assign wmask = 8'hFF >> (4'd8 - w_q);
  assign hmask = 8'hFF >> (4'd8 - h_q);

  assign x0 = u_q & wmask;
  assign x1 = (x0 + 8'd1) & wmask;
  assign y0 = v_q & hmask;
  assign y1 = (y0 + 8'd1) & hmask;

  // Issue order 00,10,01,11: bit 0 of the issue count picks x, bit 1 picks y.
  assign x_sel   = issued_q[0] ? x1 : x0;
  assign y_sel   = issued_q[1] ? y1 : y0;
  assign y_off   = {8'd0, y_sel} << w_q;
  assign tex_off = y_off + {8'd0, x_sel};
  assign addr    = base_q + ADDR_W'(tex_off);

  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = (state_q == FETCH) && !issued_q[2];
  assign mem_addr      = mem_req_valid ? addr : '0;
  assign bi_en         = (state_q == FILTER);
  assign out_valid     = (state_q == DONE);
  assign out_color     = out_valid ? bi_color : '0;
  assign tex00         = tex00_q;
  assign tex10         = tex10_q;
  assign tex01         = tex01_q;
  assign tex11         = tex11_q;
  assign fracu         = fracu_q;
  assign fracv         = fracv_q;
  assign dbg_state     = state_q;

  assign mem_fire = mem_req_valid && mem_req_ready;
  // Returns beyond the number of outstanding reads are dropped.
  assign ret_fire = mem_rdata_valid && (returned_q < issued_q);

  always_comb begin
    state_d    = state_q;
    u_d        = u_q;
    v_d        = v_q;
    base_d     = base_q;
    w_d        = w_q;
    h_d        = h_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    tex00_d    = tex00_q;
    tex10_d    = tex10_q;
    tex01_d    = tex01_q;
    tex11_d    = tex11_q;
    fracu_d    = fracu_q;
    fracv_d    = fracv_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          u_d        = req_u[15:8];
          v_d        = req_v[15:8];
          base_d     = req_base;
          w_d        = w_clamp;
          h_d        = h_clamp;
          fracu_d    = req_u[7:0];
          fracv_d    = req_v[7:0];
          issued_d   = 3'd0;
          returned_d = 3'd0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (mem_fire) begin
          issued_d = issued_q + 3'd1;
        end
        if (ret_fire) begin
          case (returned_q[1:0])
            2'd0:    tex00_d = mem_rdata;
            2'd1:    tex10_d = mem_rdata;
            2'd2:    tex01_d = mem_rdata;
            default: tex11_d = mem_rdata;
          endcase
          returned_d = returned_q + 3'd1;
          if (returned_q == 3'd3) begin
            state_d = FILTER;
          end
        end
      end
      FILTER: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      u_q        <= '0;
      v_q        <= '0;
      base_q     <= '0;
      w_q        <= '0;
      h_q        <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      tex00_q    <= '0;
      tex10_q    <= '0;
      tex01_q    <= '0;
      tex11_q    <= '0;
      fracu_q    <= '0;
      fracv_q    <= '0;
    end else begin
      state_q    <= state_d;
      u_q        <= u_d;
      v_q        <= v_d;
      base_q     <= base_d;
      w_q        <= w_d;
      h_q        <= h_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      tex00_q    <= tex00_d;
      tex10_q    <= tex10_d;
      tex01_q    <= tex01_d;
      tex11_q    <= tex11_d;
      fracu_q    <= fracu_d;
      fracv_q    <= fracv_d;
    end
  end

endmodule

// File: tb/tb_bilinear_fetch_ctrl.sv
// Bench for bilinear_fetch_ctrl: table of sample requests with known texel addresses,
// a reactive texture memory, a stub filter and an expected-result queue.
module tb_bilinear_fetch_ctrl;
  localparam int UV_W   = 16;
  localparam int ADDR_W = 20;
  localparam int EXP_W  = 176;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready;
  logic [UV_W-1:0]   req_u, req_v;
  logic [ADDR_W-1:0] req_base;
  logic [3:0]        req_wlog2, req_hlog2;
  logic              mem_req_valid, mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rdata_valid;
  logic [31:0]       mem_rdata;
  logic [31:0]       tex00, tex10, tex01, tex11;
  logic [7:0]        fracu, fracv;
  logic              bi_en;
  logic [31:0]       bi_color = 32'h0;
  logic              out_valid, out_ready;
  logic [31:0]       out_color;
  logic [1:0]        dbg_state;

  bilinear_fetch_ctrl #(.UV_W(UV_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_u(req_u), .req_v(req_v), .req_base(req_base),
    .req_wlog2(req_wlog2), .req_hlog2(req_hlog2),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .tex00(tex00), .tex10(tex10), .tex01(tex01), .tex11(tex11),
    .fracu(fracu), .fracv(fracv), .bi_en(bi_en), .bi_color(bi_color),
    .out_valid(out_valid), .out_ready(out_ready), .out_color(out_color),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic [15:0] u, v;
    logic [19:0] base;
    logic [3:0]  wl, hl;
    logic [19:0] a0, a1, a2, a3;
    logic [7:0]  fu, fv;
    bit          rnd;
    int          lat;
    int          ostall;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    int          due;
  } ret_t;

  vec_t              vecs[7];
  logic [EXP_W-1:0]  exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  ret_t              pend_q[$];
  int                n_chk = 0;
  int                n_err = 0;
  int                cyc = 0;
  int                n_issued = 0;
  int                bi_cnt = 0;
  int                acc_cyc = 0;
  logic [31:0]       salt;
  bit                rnd_ready = 0;
  int                lat = 1;
  bit                spur = 0;
  bit                stall_pend = 0;
  logic [ADDR_W-1:0] stall_addr;

  // ---------------- clock / cycle counter / filter stub ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] filt(input logic [31:0] t00, t10, t01, t11,
                                       input logic [7:0] fu, fv);
    return (t00 + {t10[30:0], 1'b0} + {t01[29:0], 2'b00} + {t11[28:0], 3'b000})
           ^ {fu, fv, 16'h0000};
  endfunction

  // The filter registers its colour one cycle after bi_en.
  always @(posedge clk) if (bi_en) bi_color <= filt(tex00, tex10, tex01, tex11, fracu, fracv);

  function automatic logic [31:0] mdata(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'h5A3C, a[19:4]} ^ salt;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tmo_fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_tex00"}, tex00, 0);
    chk({tag, "_tex10"}, tex10, 0);
    chk({tag, "_tex01"}, tex01, 0);
    chk({tag, "_tex11"}, tex11, 0);
    chk({tag, "_fracu"}, fracu, 0);
    chk({tag, "_fracv"}, fracv, 0);
    chk({tag, "_bi_en"}, bi_en, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_color"}, out_color, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_exp(input vec_t t);
    logic [31:0] d0, d1, d2, d3;
    d0 = mdata(t.a0);
    d1 = mdata(t.a1);
    d2 = mdata(t.a2);
    d3 = mdata(t.a3);
    exp_q.push_back({d0, d1, d2, d3, t.fu, t.fv, filt(d0, d1, d2, d3, t.fu, t.fv)});
    exp_addr_q.push_back(t.a0);
    exp_addr_q.push_back(t.a1);
    exp_addr_q.push_back(t.a2);
    exp_addr_q.push_back(t.a3);
  endtask

  // Call away from the rising edge; returns just after the accepting edge.
  task automatic send_req(input int i, input bit hold);
    int tmo;
    push_exp(vecs[i]);
    req_u     = vecs[i].u;
    req_v     = vecs[i].v;
    req_base  = vecs[i].base;
    req_wlog2 = vecs[i].wl;
    req_hlog2 = vecs[i].hl;
    req_valid = 1'b1;
    tmo = 0;
    while (!req_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (!req_ready) tmo_fail("req_accept");
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_out(output int c);
    int tmo;
    tmo = 0;
    @(negedge clk);
    while (!out_valid && tmo < 300) begin
      @(negedge clk);
      tmo++;
    end
    if (!out_valid) tmo_fail("out_valid_wait");
    c = cyc;
  endtask

  task automatic check_out();
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      tmo_fail("exp_q_empty");
      return;
    end
    e = exp_q.pop_front();
    chk("tex00", tex00, e[175:144]);
    chk("tex10", tex10, e[143:112]);
    chk("tex01", tex01, e[111:80]);
    chk("tex11", tex11, e[79:48]);
    chk("fracu", fracu, e[47:40]);
    chk("fracv", fracv, e[39:32]);
    chk("out_color", out_color, e[31:0]);
  endtask

  task automatic run_vec(input int i);
    int          c, b0;
    logic [31:0] col0;
    rnd_ready = vecs[i].rnd;
    lat       = vecs[i].lat;
    b0        = bi_cnt;
    @(negedge clk);
    send_req(i, 1'b0);
    wait_out(c);
    if (!vecs[i].rnd && vecs[i].lat == 1) chk("latency", c - acc_cyc, 6);
    col0 = out_color;
    for (int k = 0; k < vecs[i].ostall; k++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_color", out_color, col0);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_bi_en", bi_en, 0);
    end
    check_out();
    chk("bi_en_pulses", bi_cnt - b0, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_drop", out_valid, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int i0, tmo, b0;
    int oc[3];
    rst_n           = 1'b0;
    req_valid       = 1'b0;
    req_u           = '0;
    req_v           = '0;
    req_base        = '0;
    req_wlog2       = '0;
    req_hlog2       = '0;
    mem_req_ready   = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    out_ready       = 1'b0;
    salt            = $urandom;
    //            u        v        base      wl    hl    a0        a1        a2        a3        fu     fv   rnd lat stall
    vecs[0] = '{16'h0380, 16'h0240, 20'h00100, 4'd4, 4'd4, 20'h00123, 20'h00124, 20'h00133, 20'h00134, 8'h80, 8'h40, 0, 1, 0};
    vecs[1] = '{16'h0F10, 16'h0F00, 20'h00100, 4'd4, 4'd4, 20'h001FF, 20'h001F0, 20'h0010F, 20'h00100, 8'h10, 8'h00, 0, 1, 0};
    vecs[2] = '{16'hFFFF, 16'h12AB, 20'h00000, 4'd12, 4'd9, 20'h012FF, 20'h01200, 20'h013FF, 20'h01300, 8'hFF, 8'hAB, 0, 1, 0};
    vecs[3] = '{16'h1234, 16'h5678, 20'hFFFFF, 4'd0, 4'd0, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 8'h34, 8'h78, 0, 1, 0};
    vecs[4] = '{16'h0510, 16'h0703, 20'hFFFF0, 4'd8, 4'd2, 20'h002F5, 20'h002F6, 20'hFFFF5, 20'hFFFF6, 8'h10, 8'h03, 0, 2, 0};
    vecs[5] = '{16'h0780, 16'h1F20, 20'h00040, 4'd3, 4'd5, 20'h0013F, 20'h00138, 20'h00047, 20'h00040, 8'h80, 8'h20, 1, 3, 0};
    vecs[6] = '{16'h0380, 16'h0240, 20'h00100, 4'd4, 4'd4, 20'h00123, 20'h00124, 20'h00133, 20'h00134, 8'h80, 8'h40, 0, 1, 10};

    // Texture memory: decides ready/returns between rising edges, in issue order.
    fork
      forever begin
        @(negedge clk);
        if (bi_en) bi_cnt++;
        if (!rst_n) begin
          pend_q.delete();
          exp_addr_q.delete();
          mem_req_ready   = 1'b0;
          mem_rdata_valid = 1'b0;
          stall_pend      = 1'b0;
        end else begin
          if (stall_pend) begin
            chk("mem_addr_stall", mem_addr, stall_addr);
            stall_pend = 1'b0;
          end
          if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = pend_q[0].d;
            void'(pend_q.pop_front());
          end else if (spur && req_ready) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = 32'hDEAD_BEEF;
          end else begin
            mem_rdata_valid = 1'b0;
            mem_rdata       = $urandom;
          end
          mem_req_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
          if (mem_req_valid && mem_req_ready) begin
            if (exp_addr_q.size() == 0) tmo_fail("unexpected_read");
            else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
            pend_q.push_back('{mdata(mem_addr), cyc + lat});
            n_issued++;
          end else if (mem_req_valid) begin
            stall_pend = 1'b1;
            stall_addr = mem_addr;
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Stray read data while idle must not disturb the next sample.
    @(negedge clk);
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    run_vec(1);

    // Reset in the middle of a fetch, after two reads were issued.
    rnd_ready = 0;
    lat       = 1;
    @(negedge clk);
    i0 = n_issued;
    send_req(0, 1'b0);
    tmo = 0;
    while (n_issued - i0 < 2 && tmo < 50) begin
      @(posedge clk);
      tmo++;
    end
    if (n_issued - i0 < 2) tmo_fail("two_reads_issued");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_req_ready", req_ready, 1);
    run_vec(0);

    // Back-to-back samples with both handshakes held open.
    rnd_ready = 0;
    lat       = 1;
    spur      = 1'b1;
    out_ready = 1'b1;
    b0        = bi_cnt;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 3; k++) send_req(k, 1'b1);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_out(oc[k]);
          check_out();
        end
      end
    join
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    spur      = 1'b0;
    chk("b2b_period_1", oc[1] - oc[0], 8);
    chk("b2b_period_2", oc[2] - oc[1], 8);
    chk("b2b_bi_en_pulses", bi_cnt - b0, 3);
    @(negedge clk);
    chk("final_idle", req_ready, 1);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("addr_q_drained", exp_addr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
